// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared state encoding and BCD digit width for the serial
//               binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int c_bcd_w = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Double-dabble digit correction: add 3 when the digit is >= 5.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [c_bcd_w-1:0] i_digit,
    output logic [c_bcd_w-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= c_bcd_w'(5)) begin
            o_digit = i_digit + c_bcd_w'(3);
        end
    end

endmodule
`default_nettype wire

// File: rtl/binary_to_bcd_serial.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_bcd_serial
// Description : Serial (one bit per clock) double-dabble binary-to-BCD
//               converter with overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_to_bcd_serial
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [WIDTH-1:0]            i_binary,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [c_bcd_w*DIGITS-1:0]   o_bcd,
    output logic                        o_overflow
);

    localparam int c_cnt_w  = $clog2(WIDTH + 1);
    localparam int c_scr_w  = c_bcd_w * DIGITS;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [WIDTH-1:0]       r_bin;
    logic [c_scr_w-1:0]     r_scratch;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_ovf_acc;
    logic [c_scr_w-1:0]     r_bcd;
    logic                   r_ovf;

    logic [c_scr_w-1:0]     w_adj;
    logic [c_scr_w-1:0]     w_shifted;
    logic                   w_out_bit;
    logic                   w_accept;
    logic                   w_last;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_adj u_adj (
                .i_digit (r_scratch[g*c_bcd_w +: c_bcd_w]),
                .o_digit (w_adj[g*c_bcd_w +: c_bcd_w])
            );
        end
    endgenerate

    // Shift the adjusted scratch left, pulling in the next binary MSB;
    // the bit leaving the top digit flags a value >= 10^DIGITS.
    assign w_shifted = {w_adj[c_scr_w-2:0], r_bin[WIDTH-1]};
    assign w_out_bit = w_adj[c_scr_w-1];
    assign w_accept  = i_start && (r_state != ST_SHIFT);
    assign w_last    = (r_cnt == c_cnt_w'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_last)  w_next_state = ST_DONE;
            ST_DONE:  w_next_state = i_start ? ST_SHIFT : ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == ST_SHIFT);
        o_done = (r_state == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_bin     <= i_binary;
            r_scratch <= '0;
            r_cnt     <= c_cnt_w'(WIDTH);
            r_ovf_acc <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            r_scratch <= w_shifted;
            r_bin     <= r_bin << 1;
            r_ovf_acc <= r_ovf_acc | w_out_bit;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
            if (w_last) begin
                r_bcd <= w_shifted;
                r_ovf <= r_ovf_acc | w_out_bit;
            end
        end
    end

    assign o_bcd      = r_bcd;
    assign o_overflow = r_ovf;

endmodule
`default_nettype wire
